gpio_word_presenter: RTL and testbench

Sits between the pepe floating-point datapath and the user GPIO pads mprj_io[7:0]. It accepts one DATA_W-bit result word per valid/ready handshake and presents it on IO_W pad outputs, one byte at a time. Each byte is held for HOLD_CYCLES clocks. The last byte stays on the pads after the frame ends, so the chip-level bench and external probes can sample a stable pattern.

---
 rtl/gpio_word_presenter_if.sv | 8 +
 rtl/gpio_word_presenter.sv | 100 ++++++++++
 tb/tb_gpio_word_presenter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_word_presenter_if.sv
// gpio_word_presenter_if: valid/ready word handshake between the datapath and the pad presenter
interface gpio_word_presenter_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  modport master (output in_valid, output in_data, input in_ready);
  modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/gpio_word_presenter.sv
// gpio_word_presenter: shows each accepted word on the GPIO pads one byte at a time, leaving the last byte parked
module gpio_word_presenter #(
  parameter int DATA_W      = 32,
  parameter int IO_W        = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int MSB_FIRST   = 1
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 enable,
  gpio_word_presenter_if.slave bus,
  output logic [IO_W-1:0]      io_out,
  output logic [IO_W-1:0]      io_oeb,
  output logic                 byte_strobe,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int NBYTES = DATA_W / IO_W;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int XW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [XW-1:0] LAST_IDX = XW'(NBYTES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [IO_W-1:0]   out_n;
  logic [HW-1:0]     hold, hold_n;
  logic [XW-1:0]     idx, idx_n;
  logic              strobe_n, done_n;

  function automatic logic [IO_W-1:0] lead(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1 -: IO_W] : w[IO_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w << IO_W : w >> IO_W;
  endfunction

  assign bus.in_ready = enable && state == IDLE;
  assign busy = state == SHOW;

  // Next state: accept in IDLE, count down each byte's hold, step to the next byte, finish or abort
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    out_n    = io_out;
    hold_n   = hold;
    idx_n    = idx;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        state_n  = SHOW;
        shreg_n  = bus.in_data;
        out_n    = lead(bus.in_data);
        strobe_n = 1'b1;
        hold_n   = HOLD_RELOAD;
        idx_n    = '0;
      end
    end else if (hold != '0) begin
      hold_n = hold - 1'b1;
    end else if (idx != LAST_IDX) begin
      shreg_n  = advance(shreg);
      out_n    = lead(advance(shreg));
      strobe_n = 1'b1;
      idx_n    = idx + 1'b1;
      hold_n   = HOLD_RELOAD;
    end else begin
      state_n = IDLE;
      done_n  = 1'b1;
    end
  end

  // State and pad registers; pad drive follows enable one cycle late
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      shreg       <= '0;
      io_out      <= '0;
      io_oeb      <= '1;
      hold        <= '0;
      idx         <= '0;
      byte_strobe <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      io_out      <= out_n;
      io_oeb      <= {IO_W{!enable}};
      hold        <= hold_n;
      idx         <= idx_n;
      byte_strobe <= strobe_n;
      frame_done  <= done_n;
    end
  end
endmodule

// File: tb/tb_gpio_word_presenter.sv
// tb_gpio_word_presenter: randomized scoreboard bench for two presenter configurations sharing one stimulus
module tb_gpio_word_presenter;
  localparam int NB = 4;

  logic        clock = 1'b0;
  logic        resetb = 1'b1;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data = '0;

  always #5 clock = ~clock;

  gpio_word_presenter_if #(.DATA_W(32)) bus0 ();
  gpio_word_presenter_if #(.DATA_W(32)) bus1 ();
  assign bus0.in_valid = valid;
  assign bus0.in_data  = data;
  assign bus1.in_valid = valid;
  assign bus1.in_data  = data;

  logic [7:0] io_out [2];
  logic [7:0] io_oeb [2];
  logic       strobe [2];
  logic       busy [2];
  logic       done [2];
  logic       rdy [2];
  assign rdy[0] = bus0.in_ready;
  assign rdy[1] = bus1.in_ready;

  gpio_word_presenter #(.DATA_W(32), .IO_W(8), .HOLD_CYCLES(4), .MSB_FIRST(1)) dut0 (
    .clock(clock), .resetb(resetb), .enable(en), .bus(bus0),
    .io_out(io_out[0]), .io_oeb(io_oeb[0]), .byte_strobe(strobe[0]),
    .busy(busy[0]), .frame_done(done[0])
  );

  gpio_word_presenter #(.DATA_W(32), .IO_W(8), .HOLD_CYCLES(1), .MSB_FIRST(0)) dut1 (
    .clock(clock), .resetb(resetb), .enable(en), .bus(bus1),
    .io_out(io_out[1]), .io_oeb(io_oeb[1]), .byte_strobe(strobe[1]),
    .busy(busy[1]), .frame_done(done[1])
  );

  int compared = 0;
  int mismatched = 0;
  int busy_cnt [2];
  int strobe_cnt [2];
  int done_cnt [2];

  bit         m_busy [2];
  int         m_t [2];
  logic [31:0] m_word [2];
  logic [7:0] m_out [2];
  logic [7:0] m_oeb [2];
  bit         m_strobe [2];
  bit         m_done [2];
  logic [7:0] sb [2][$];

  function automatic int hold_of(input int k);
    return k == 0 ? 4 : 1;
  endfunction

  function automatic logic [7:0] byte_at(input int k, input logic [31:0] w, input int i);
    int sh;
    sh = (k == 0) ? 8 * (NB - 1 - i) : 8 * i;
    return 8'(w >> sh);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      busy_cnt[k] = 0;
      strobe_cnt[k] = 0;
      done_cnt[k] = 0;
    end
  endtask

  task automatic send(input logic [31:0] w);
    valid = 1'b1;
    data = w;
    wait_cyc(1);
    valid = 1'b0;
  endtask

  // Reference model: a frame is NB*hold cycles long, byte i starts at cycle i*hold of the frame
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_t[k] = 0; m_word[k] = '0; m_out[k] = '0;
      m_oeb[k] = 8'hFF; m_strobe[k] = 0; m_done[k] = 0;
    end
    forever begin
      @(posedge clock or negedge resetb);
      for (int k = 0; k < 2; k++) begin
        if (!resetb) begin
          m_busy[k] = 0; m_t[k] = 0; m_out[k] = '0; m_oeb[k] = 8'hFF;
          m_strobe[k] = 0; m_done[k] = 0; sb[k].delete();
        end else begin
          m_strobe[k] = 0;
          m_done[k] = 0;
          m_oeb[k] = en ? 8'h00 : 8'hFF;
          if (!en) begin
            m_busy[k] = 0;
            sb[k].delete();
          end else if (!m_busy[k]) begin
            if (valid) begin
              m_busy[k] = 1;
              m_t[k] = 0;
              m_word[k] = data;
              for (int i = 0; i < NB; i++) sb[k].push_back(byte_at(k, data, i));
              m_out[k] = byte_at(k, data, 0);
              m_strobe[k] = 1;
            end
          end else begin
            m_t[k]++;
            if (m_t[k] == NB * hold_of(k)) begin
              m_busy[k] = 0;
              m_done[k] = 1;
            end else if (m_t[k] % hold_of(k) == 0) begin
              m_out[k] = byte_at(k, m_word[k], m_t[k] / hold_of(k));
              m_strobe[k] = 1;
            end
          end
        end
      end
    end
  end

  // Monitor: every falling edge compare pads/flags with the model and pop bytes on each strobe
  initial begin
    forever begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("io_out%0d", k), 32'(io_out[k]), 32'(m_out[k]));
        chk($sformatf("io_oeb%0d", k), 32'(io_oeb[k]), 32'(m_oeb[k]));
        chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
        chk($sformatf("strobe%0d", k), 32'(strobe[k]), 32'(m_strobe[k]));
        chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
        chk($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'(en && !m_busy[k]));
        if (strobe[k] === 1'b1) begin
          if (sb[k].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL sb_byte%0d at %0t: got strobe with byte %h, expected no byte", k, $time, io_out[k]);
          end else begin
            chk($sformatf("sb_byte%0d", k), 32'(io_out[k]), 32'(sb[k].pop_front()));
          end
        end
        busy_cnt[k] += (busy[k] === 1'b1) ? 1 : 0;
        strobe_cnt[k] += (strobe[k] === 1'b1) ? 1 : 0;
        done_cnt[k] += (done[k] === 1'b1) ? 1 : 0;
      end
    end
  end

  initial begin
    clr();
    #1 resetb = 1'b0;
    wait_cyc(5);
    chk("rst_io_out", 32'(io_out[0]), 32'h00);
    chk("rst_io_oeb", 32'(io_oeb[0]), 32'hFF);
    chk("rst_in_ready", 32'(rdy[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    resetb = 1'b1;
    wait_cyc(1);

    clr();
    en = 1'b1;
    send(32'hC128_A54F);
    wait_cyc(20);
    chk("f1_busy_cycles", 32'(busy_cnt[0]), 32'd16);
    chk("f1_strobes", 32'(strobe_cnt[0]), 32'd4);
    chk("f1_done", 32'(done_cnt[0]), 32'd1);
    chk("f1_last_byte", 32'(io_out[0]), 32'h4F);
    chk("f1_h1_busy_cycles", 32'(busy_cnt[1]), 32'd4);
    chk("f1_h1_last_byte", 32'(io_out[1]), 32'hC1);

    clr();
    send(32'h1234_5678);
    wait_cyc(20);
    chk("f2_h1_strobes", 32'(strobe_cnt[1]), 32'd4);
    chk("f2_h1_busy_cycles", 32'(busy_cnt[1]), 32'd4);
    chk("f2_h1_last_byte", 32'(io_out[1]), 32'h12);
    chk("f2_last_byte", 32'(io_out[0]), 32'h78);

    clr();
    valid = 1'b1;
    data = 32'h1111_1111;
    wait_cyc(1);
    data = 32'h2222_2222;
    wait_cyc(40);
    valid = 1'b0;
    wait_cyc(20);
    chk("b2b_frames", 32'(done_cnt[0]), 32'd3);
    chk("b2b_strobes", 32'(strobe_cnt[0]), 32'd12);
    chk("b2b_last_byte", 32'(io_out[0]), 32'h22);

    clr();
    send(32'hAABB_CCDD);
    wait_cyc(5);
    en = 1'b0;
    wait_cyc(1);
    chk("abort_busy", 32'(busy[0]), 32'h0);
    chk("abort_oeb", 32'(io_oeb[0]), 32'hFF);
    chk("abort_hold_byte", 32'(io_out[0]), 32'hBB);
    wait_cyc(3);
    chk("abort_no_done", 32'(done_cnt[0]), 32'd0);
    en = 1'b1;
    wait_cyc(1);
    send(32'h0102_0304);
    wait_cyc(20);
    chk("after_abort_last", 32'(io_out[0]), 32'h04);

    send(32'h5566_7788);
    wait_cyc(8);
    resetb = 1'b0;
    #1;
    chk("arst_io_out", 32'(io_out[0]), 32'h00);
    chk("arst_io_oeb", 32'(io_oeb[0]), 32'hFF);
    chk("arst_busy", 32'(busy[0]), 32'h0);
    wait_cyc(2);
    resetb = 1'b1;
    wait_cyc(1);
    send(32'h0A0B_0C0D);
    wait_cyc(20);
    chk("post_rst_last", 32'(io_out[0]), 32'h0D);
    chk("post_rst_h1_last", 32'(io_out[1]), 32'h0A);

    repeat (400) begin
      en = ($urandom_range(0, 15) != 0);
      valid = ($urandom_range(0, 2) != 0);
      data = $urandom;
      wait_cyc(1);
    end
    en = 1'b1;
    valid = 1'b0;
    wait_cyc(30);
    chk("sb0_drained", 32'(sb[0].size()), 32'd0);
    chk("sb1_drained", 32'(sb[1].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
